// File: rtl/key_debounce_if.sv
// Pushbutton conditioning bus: raw pins in, debounced levels and optional event pulses out.
// key_press/key_release exist only when KEY_DEBOUNCE_EVENT_EN is defined.
interface key_debounce_if #(
    parameter int unsigned NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_level;
    logic                key_any;
`ifdef KEY_DEBOUNCE_EVENT_EN
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
`endif

`ifdef KEY_DEBOUNCE_EVENT_EN
    modport master (output key_raw, input key_level, key_any, key_press, key_release);
    modport slave  (input key_raw, output key_level, key_any, key_press, key_release);
`else
    modport master (output key_raw, input key_level, key_any);
    modport slave  (input key_raw, output key_level, key_any);
`endif
endinterface

// File: rtl/key_debounce.sv
// Per-key 2-FF synchronizer plus consecutive-sample debounce feeding the HPS keys PIO.
// Optional one-cycle press/release pulses when KEY_DEBOUNCE_EVENT_EN is defined.
module key_debounce #(
    parameter int unsigned NUM_KEYS         = 4,
    parameter int unsigned CLK_HZ           = 50000000,
    parameter int unsigned DEBOUNCE_US      = 10000,
    parameter bit          INPUT_ACTIVE_LOW = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    key_debounce_if.slave bus
);
    localparam int unsigned DB_RAW    = (CLK_HZ / 1000000) * DEBOUNCE_US;
    localparam int unsigned DB_CYCLES = (DB_RAW < 1) ? 1 : DB_RAW;
    localparam int unsigned CNT_W     = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [NUM_KEYS-1:0] IDLE    = {NUM_KEYS{INPUT_ACTIVE_LOW}};

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] level_q, level_d;
    logic                any_q;
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] pressed;

    assign pressed = sync2_q ^ IDLE;

    // Counter only advances while the sample disagrees with the stable level.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            cnt_d[i] = '0;
            if (pressed[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i] = pressed[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= IDLE;
            sync2_q <= IDLE;
            level_q <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < int'(NUM_KEYS); i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= bus.key_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            any_q   <= |level_d;
            for (int i = 0; i < int'(NUM_KEYS); i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.key_level = level_q;
    assign bus.key_any   = any_q;

`ifdef KEY_DEBOUNCE_EVENT_EN
    logic [NUM_KEYS-1:0] prev_q;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] release_q, release_d;

    // Pulses land the cycle after the level edge; clearing prev with level avoids a reset release.
    always_comb begin
        press_d   = level_q & ~prev_q;
        release_d = ~level_q & prev_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q    <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            prev_q    <= level_q;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign bus.key_press   = press_q;
    assign bus.key_release = release_q;
`endif
endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DB_CYCLES=8, active-low keys, four channels.
`timescale 1ns/1ps
module tb_key_debounce;
    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    key_debounce_if #(.NUM_KEYS(4)) bus ();

    key_debounce #(
        .NUM_KEYS(4), .CLK_HZ(1000000), .DEBOUNCE_US(8), .INPUT_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_lvl(input string tag, input logic [3:0] lvl);
        check({tag, ".level"}, {4'h0, bus.key_level}, {4'h0, lvl});
        check({tag, ".any"}, {7'h0, bus.key_any}, {7'h0, |lvl});
    endtask

    task automatic check_ev(input string tag, input logic [3:0] prs, input logic [3:0] rel);
`ifdef KEY_DEBOUNCE_EVENT_EN
        check({tag, ".press"}, {4'h0, bus.key_press}, {4'h0, prs});
        check({tag, ".release"}, {4'h0, bus.key_release}, {4'h0, rel});
`else
        if (prs !== 4'hx && rel !== 4'hx) begin end
`endif
    endtask

    initial begin
        reset_n     = 1'b0;
        bus.key_raw = 4'hF;
        tick(3);
        check_lvl("reset_held", 4'h0);
        check_ev("reset_held", 4'h0, 4'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_lvl("idle_after_reset", 4'h0);
        end

        // Key 0 press: level flips exactly at edge 10.
        bus.key_raw = 4'hE;
        tick(9);
        check_lvl("k0_edge9", 4'h0);
        tick(1);
        check_lvl("k0_edge10", 4'h1);
        check_ev("k0_edge10", 4'h0, 4'h0);
        tick(1);
        check_ev("k0_edge11", 4'h1, 4'h0);
        tick(1);
        check_ev("k0_edge12", 4'h0, 4'h0);
        bus.key_raw = 4'hF;
        tick(9);
        check_lvl("k0_rel_edge9", 4'h1);
        tick(1);
        check_lvl("k0_rel_edge10", 4'h0);
        tick(1);
        check_ev("k0_rel_edge11", 4'h0, 4'h1);
        tick(3);

        // Key 1 glitch of 7 low cycles is rejected.
        bus.key_raw = 4'hD;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            check_lvl("k1_glitch7", 4'h0);
        end
        bus.key_raw = 4'hF;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check_lvl("k1_glitch7_after", 4'h0);
        end

        // 5 low, 1 high, 5 low: the high sample restarts the count.
        bus.key_raw = 4'hD; tick(5);
        bus.key_raw = 4'hF; tick(1);
        bus.key_raw = 4'hD; tick(5);
        bus.key_raw = 4'hF;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check_lvl("k1_gap", 4'h0);
        end
        check_ev("k1_gap", 4'h0, 4'h0);

        // Key 2 pressed, then bounce, then final release.
        bus.key_raw = 4'hB;
        tick(12);
        check_lvl("k2_pressed", 4'h4);
        for (int p = 0; p < 10; p++) begin
            bus.key_raw = (p % 2 == 0) ? 4'hF : 4'hB;
            tick(1); check_lvl("k2_bounce", 4'h4);
            tick(1); check_lvl("k2_bounce", 4'h4);
        end
        bus.key_raw = 4'hF;
        tick(9);
        check_lvl("k2_settle_edge9", 4'h4);
        tick(1);
        check_lvl("k2_settle_edge10", 4'h0);
        check_ev("k2_settle_edge10", 4'h0, 4'h0);
        tick(1);
        check_ev("k2_settle_edge11", 4'h0, 4'h4);
        tick(1);
        check_ev("k2_settle_edge12", 4'h0, 4'h0);
        tick(3);

        // Keys 0 and 3 on the same edge.
        bus.key_raw = 4'h6;
        tick(9);
        check_lvl("k03_edge9", 4'h0);
        tick(1);
        check_lvl("k03_edge10", 4'h9);
        tick(1);
        check_ev("k03_edge11", 4'h9, 4'h0);
        tick(1);
        check_ev("k03_edge12", 4'h0, 4'h0);
        bus.key_raw = 4'hF;
        tick(12);
        check_lvl("k03_released", 4'h0);

        // Key 1 held across a one-cycle reset pulse.
        bus.key_raw = 4'hD;
        tick(12);
        check_lvl("k1_held", 4'h2);
        reset_n = 1'b0;
        #1;
        check_lvl("k1_reset_async", 4'h0);
        check_ev("k1_reset_async", 4'h0, 4'h0);
        tick(1);
        check_ev("k1_in_reset", 4'h0, 4'h0);
        reset_n = 1'b1;
        tick(1);
        check_ev("k1_post_reset_edge1", 4'h0, 4'h0);
        tick(8);
        check_lvl("k1_post_reset_edge9", 4'h0);
        tick(1);
        check_lvl("k1_post_reset_edge10", 4'h2);
        tick(1);
        check_ev("k1_post_reset_edge11", 4'h2, 4'h0);
        tick(1);
        check_ev("k1_post_reset_edge12", 4'h0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
